// File: rtl/nand4_resp_checker.sv
// Response checker for a 4-bit NAND stimulus stream: compares each sampled y
// against ~(a & b), counts vectors and mismatches, and latches the first failure.
module nand4_resp_checker #(
    parameter int WIDTH       = 4,
    parameter int NUM_VECTORS = 19,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH-1:0] first_err_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] ERR_MAX    = {CNT_W{1'b1}};

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   vec_count_reg, vec_count_next;
    logic [CNT_W-1:0]   err_count_reg, err_count_next;
    logic [CNT_W-1:0]   first_idx_reg, first_idx_next;
    logic [WIDTH-1:0]   first_a_reg, first_a_next;
    logic [WIDTH-1:0]   first_b_reg, first_b_next;
    logic [WIDTH-1:0]   first_y_reg, first_y_next;
    logic               first_seen_reg, first_seen_next;
    logic               err_pulse_reg, err_pulse_next;

    logic [WIDTH-1:0]   expected_y;
    logic               mismatch;
    logic [CNT_W-1:0]   vec_count_inc;

    assign expected_y    = ~(in_a & in_b);
    assign mismatch      = (in_y != expected_y);
    assign vec_count_inc = vec_count_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            vec_count_reg  <= '0;
            err_count_reg  <= '0;
            first_idx_reg  <= '0;
            first_a_reg    <= '0;
            first_b_reg    <= '0;
            first_y_reg    <= '0;
            first_seen_reg <= 1'b0;
            err_pulse_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vec_count_reg  <= vec_count_next;
            err_count_reg  <= err_count_next;
            first_idx_reg  <= first_idx_next;
            first_a_reg    <= first_a_next;
            first_b_reg    <= first_b_next;
            first_y_reg    <= first_y_next;
            first_seen_reg <= first_seen_next;
            err_pulse_reg  <= err_pulse_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        vec_count_next  = vec_count_reg;
        err_count_next  = err_count_reg;
        first_idx_next  = first_idx_reg;
        first_a_next    = first_a_reg;
        first_b_next    = first_b_reg;
        first_y_next    = first_y_reg;
        first_seen_next = first_seen_reg;
        err_pulse_next  = 1'b0;

        if (abort) begin
            // Abort leaves results visible; only the next start clears them.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next      = RUN;
                        vec_count_next  = '0;
                        err_count_next  = '0;
                        first_idx_next  = '0;
                        first_a_next    = '0;
                        first_b_next    = '0;
                        first_y_next    = '0;
                        first_seen_next = 1'b0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        vec_count_next = vec_count_inc;
                        if (mismatch) begin
                            err_pulse_next = 1'b1;
                            if (err_count_reg != ERR_MAX) begin
                                err_count_next = err_count_reg + 1'b1;
                            end
                            if (!first_seen_reg) begin
                                first_seen_next = 1'b1;
                                first_idx_next  = vec_count_reg;
                                first_a_next    = in_a;
                                first_b_next    = in_b;
                                first_y_next    = in_y;
                            end
                        end
                        if (vec_count_inc == LAST_COUNT) begin
                            state_next = DONE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy          = (state_reg == RUN);
    assign done          = (state_reg == DONE);
    assign pass          = (state_reg == DONE) && (err_count_reg == '0);
    assign err_pulse     = err_pulse_reg;
    assign vec_count     = vec_count_reg;
    assign err_count     = err_count_reg;
    assign first_err_idx = first_idx_reg;
    assign first_err_a   = first_a_reg;
    assign first_err_b   = first_b_reg;
    assign first_err_y   = first_y_reg;

endmodule

// File: tb/tb_nand4_resp_checker.sv
// Bench for nand4_resp_checker: table of stream scenarios, scoreboard of
// expected per-vector responses, plus reset/abort/restart sequences.
module tb_nand4_resp_checker;

    localparam int W = 4;
    localparam int N = 19;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] in_y = '0;
    logic         busy, done, pass, err_pulse;
    logic [C-1:0] vec_count, err_count, first_err_idx;
    logic [W-1:0] first_err_a, first_err_b, first_err_y;

    nand4_resp_checker #(.WIDTH(W), .NUM_VECTORS(N), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
        .vec_count(vec_count), .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_a(first_err_a), .first_err_b(first_err_b), .first_err_y(first_err_y)
    );

    always #5 clk = ~clk;

    typedef struct { logic err; logic [C-1:0] vc; } sb_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } vec_t;
    typedef struct {
        string        name;
        logic [N-1:0] bad;
        bit           gaps;
        int           e_err;
        int           e_idx;
        bit           e_pass;
    } scen_t;

    sb_t   sb_q[$];
    vec_t  tbl[N];
    scen_t scen[4];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] good_y(input logic [W-1:0] a, input logic [W-1:0] b);
        return ~(a & b);
    endfunction

    function automatic logic [W-1:0] vec_y(input int i, input bit corrupt);
        logic [W-1:0] y;
        y = good_y(tbl[i].a, tbl[i].b);
        return corrupt ? (y ^ 4'h1) : y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; accepted vectors go through the scoreboard.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] y,
                        input logic v, input logic st, input logic ab,
                        input bit acc, input logic exp_err, input int exp_vc);
        sb_t e;
        in_a = a; in_b = b; in_y = y; in_valid = v; start = st; abort = ab;
        if (acc) sb_q.push_back('{err: exp_err, vc: C'(exp_vc)});
        tick();
        if (acc) begin
            e = sb_q.pop_front();
            chk("err_pulse", {31'd0, err_pulse}, {31'd0, e.err});
            chk("vec_count", {24'd0, vec_count}, {24'd0, e.vc});
        end else begin
            chk("err_pulse_quiet", {31'd0, err_pulse}, 32'd0);
        end
        in_valid = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic do_start(input logic with_valid);
        step(4'h3, 4'hF, 4'h0, with_valid, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_vec", {24'd0, vec_count}, 32'd0);
        chk("start_err", {24'd0, err_count}, 32'd0);
    endtask

    task automatic run_stream(input scen_t s);
        bit bad_i;
        if (s.gaps) begin
            for (int k = 0; k < 2; k++) begin
                step(4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                chk({s.name, "_done_ignore"}, {24'd0, vec_count}, N);
            end
        end
        do_start(s.gaps);
        for (int i = 0; i < N; i++) begin
            if (s.gaps && (i % 3 == 1)) begin
                step(4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                chk({s.name, "_gap_vec"}, {24'd0, vec_count}, i);
            end
            bad_i = s.bad[i];
            step(tbl[i].a, tbl[i].b, vec_y(i, bad_i), 1'b1, 1'b0, 1'b0, 1'b1, bad_i, i + 1);
            chk({s.name, "_busy"}, {31'd0, busy}, (i < N - 1) ? 32'd1 : 32'd0);
            chk({s.name, "_done"}, {31'd0, done}, (i == N - 1) ? 32'd1 : 32'd0);
        end
        chk({s.name, "_pass"}, {31'd0, pass}, {31'd0, s.e_pass});
        chk({s.name, "_err_count"}, {24'd0, err_count}, s.e_err);
        if (s.e_err > 0) begin
            chk({s.name, "_first_idx"}, {24'd0, first_err_idx}, s.e_idx);
            chk({s.name, "_first_a"}, {28'd0, first_err_a}, {28'd0, tbl[s.e_idx].a});
            chk({s.name, "_first_b"}, {28'd0, first_err_b}, {28'd0, tbl[s.e_idx].b});
            chk({s.name, "_first_y"}, {28'd0, first_err_y}, {28'd0, vec_y(s.e_idx, 1'b1)});
        end
        // in_valid in DONE must be ignored and results must hold
        step(4'h0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk({s.name, "_hold_vec"}, {24'd0, vec_count}, N);
        chk({s.name, "_hold_done"}, {31'd0, done}, 32'd1);
        $display("scenario %s: err_count=%0d first_err_idx=%0d pass=%0b", s.name, err_count, first_err_idx, pass);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_pass"}, {31'd0, pass}, 32'd0);
        chk({nm, "_err_pulse"}, {31'd0, err_pulse}, 32'd0);
        chk({nm, "_counts"}, {8'd0, vec_count, err_count, first_err_idx}, 32'd0);
        chk({nm, "_first_abc"}, {20'd0, first_err_a, first_err_b, first_err_y}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{a: W'(i), b: 4'hF};
        tbl[16] = '{a: 4'h0, b: 4'h0};
        tbl[17] = '{a: 4'hF, b: 4'h0};
        tbl[18] = '{a: 4'h0, b: 4'h0};
        scen[0] = '{name: "clean",  bad: 19'h0,                           gaps: 1'b0, e_err: 0, e_idx: 0, e_pass: 1'b1};
        scen[1] = '{name: "one_err", bad: 19'h1 << 5,                     gaps: 1'b0, e_err: 1, e_idx: 5, e_pass: 1'b0};
        scen[2] = '{name: "three",  bad: (19'h1 << 2) | (19'h1 << 7) | (19'h1 << 18), gaps: 1'b0, e_err: 3, e_idx: 2, e_pass: 1'b0};
        scen[3] = '{name: "gaps",   bad: 19'h0,                           gaps: 1'b1, e_err: 0, e_idx: 0, e_pass: 1'b1};

        #3;
        chk_all_zero("reset");
        #4 rst_n = 1'b1;
        tick();
        // in_valid while IDLE is ignored
        step(4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("idle_ignore_vec", {24'd0, vec_count}, 32'd0);

        for (int s = 0; s < 4; s++) run_stream(scen[s]);

        // Reset in the middle of a run
        do_start(1'b0);
        for (int i = 0; i < 10; i++)
            step(tbl[i].a, tbl[i].b, vec_y(i, i == 3), 1'b1, 1'b0, 1'b0, 1'b1, i == 3, i + 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        sb_q.delete();
        #2 rst_n = 1'b1;
        tick();
        // Run from IDLE: no DONE-state preamble, so reuse the clean record without gaps
        run_stream(scen[0]);

        // Start during RUN is ignored; abort ends the run and clears nothing
        do_start(1'b0);
        for (int i = 0; i < 4; i++)
            step(tbl[i].a, tbl[i].b, vec_y(i, i == 1), 1'b1, (i == 2), 1'b0, 1'b1, i == 1, i + 1);
        step(tbl[4].a, tbl[4].b, vec_y(4, 1'b1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_vec", {24'd0, vec_count}, 32'd4);
        chk("abort_err", {24'd0, err_count}, 32'd1);
        chk("abort_first_idx", {24'd0, first_err_idx}, 32'd1);
        $display("abort: vec_count=%0d err_count=%0d busy=%0b", vec_count, err_count, busy);

        // Restart from IDLE after abort, then restart from DONE
        run_stream(scen[1]);
        do_start(1'b1);
        chk("restart_pass", {31'd0, pass}, 32'd0);
        chk("restart_first_idx", {24'd0, first_err_idx}, 32'd0);
        chk("restart_done", {31'd0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
